// File: rtl/seg_defs_pkg.sv
// Shared seven-segment definitions: segment bit order, hex glyphs and blink states.
// Imported by the decoder and by the scan controller.
package seg_defs;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Active-high glyphs in {g,f,e,d,c,b,a} order.
  localparam logic [6:0] HEX_0 = 7'h3F;
  localparam logic [6:0] HEX_1 = 7'h06;
  localparam logic [6:0] HEX_2 = 7'h5B;
  localparam logic [6:0] HEX_3 = 7'h4F;
  localparam logic [6:0] HEX_4 = 7'h66;
  localparam logic [6:0] HEX_5 = 7'h6D;
  localparam logic [6:0] HEX_6 = 7'h7D;
  localparam logic [6:0] HEX_7 = 7'h07;
  localparam logic [6:0] HEX_8 = 7'h7F;
  localparam logic [6:0] HEX_9 = 7'h6F;
  localparam logic [6:0] HEX_A = 7'h77;
  localparam logic [6:0] HEX_B = 7'h7C;
  localparam logic [6:0] HEX_C = 7'h39;
  localparam logic [6:0] HEX_D = 7'h5E;
  localparam logic [6:0] HEX_E = 7'h79;
  localparam logic [6:0] HEX_F = 7'h71;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    HIDDEN  = 1'b0,
    VISIBLE = 1'b1
  } blink_state_e;

endpackage

// File: rtl/seg_scan_controller_if.sv
// Bundle between the game/clock logic (master) and the display scan controller (slave).
// Width of digit_idx follows the number of digits, never below one bit.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    enable;
  logic                    blink_restart;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;
  logic [IDX_W-1:0]        digit_idx;
  logic                    blink_on;

  modport master (
    output digits, blink_mask, dp_mask, enable, blink_restart,
    input  an, seg, dp, digit_idx, blink_on
  );

  modport slave (
    input  digits, blink_mask, dp_mask, enable, blink_restart,
    output an, seg, dp, digit_idx, blink_on
  );

endinterface

// File: rtl/hex_to_7seg.sv
// Combinational nibble to seven-segment decode, active-high, {g,f,e,d,c,b,a}.
module hex_to_7seg
  import seg_defs::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (hex_i)
      4'h0: seg_o = HEX_0;
      4'h1: seg_o = HEX_1;
      4'h2: seg_o = HEX_2;
      4'h3: seg_o = HEX_3;
      4'h4: seg_o = HEX_4;
      4'h5: seg_o = HEX_5;
      4'h6: seg_o = HEX_6;
      4'h7: seg_o = HEX_7;
      4'h8: seg_o = HEX_8;
      4'h9: seg_o = HEX_9;
      4'hA: seg_o = HEX_A;
      4'hB: seg_o = HEX_B;
      4'hC: seg_o = HEX_C;
      4'hD: seg_o = HEX_D;
      4'hE: seg_o = HEX_E;
      4'hF: seg_o = HEX_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_controller.sv
// Multiplexed N-digit seven-segment driver with per-digit blink and decimal point masks.
// Counters keep running while blanked so the scan and blink phase never lose position.
module seg_scan_controller
  import seg_defs::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25000000,
  parameter int ACTIVE_LOW  = 1
) (
  input logic       clk,
  input logic       rst,
  seg_scan_if.slave scan_if
);

  localparam int   IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int   RCNT_W = $clog2(REFRESH_DIV);
  localparam int   BCNT_W = $clog2(BLINK_DIV);
  localparam logic POL    = (ACTIVE_LOW != 0);

  logic [RCNT_W-1:0]     rcnt_q, rcnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  blink_state_e          blink_q, blink_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic [3:0]            nibble;
  logic [6:0]            glyph;
  logic                  visible;
  logic [NUM_DIGITS-1:0] onehot;

  hex_to_7seg u_dec (
    .hex_i (nibble),
    .seg_o (glyph)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt_q  <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      blink_q <= VISIBLE;
      an_q    <= {NUM_DIGITS{POL}};
      seg_q   <= {7{POL}};
      dp_q    <= POL;
    end else begin
      rcnt_q  <= rcnt_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  always_comb begin
    rcnt_d = rcnt_q + RCNT_W'(1);
    idx_d  = idx_q;
    if (rcnt_q == RCNT_W'(REFRESH_DIV - 1)) begin
      rcnt_d = '0;
      idx_d  = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // A restart pulse wins over a terminal-count toggle in the same cycle.
  always_comb begin
    bcnt_d  = bcnt_q + BCNT_W'(1);
    blink_d = blink_q;
    if (scan_if.blink_restart) begin
      bcnt_d  = '0;
      blink_d = VISIBLE;
    end else if (bcnt_q == BCNT_W'(BLINK_DIV - 1)) begin
      bcnt_d  = '0;
      blink_d = (blink_q == VISIBLE) ? HIDDEN : VISIBLE;
    end
  end

  // Build the active-high image first, then flip once for the board polarity.
  always_comb begin
    nibble  = scan_if.digits[4*idx_q +: 4];
    visible = scan_if.enable && !(scan_if.blink_mask[idx_q] && (blink_q == HIDDEN));
    onehot  = '0;
    if (visible) begin
      onehot[idx_q] = 1'b1;
    end
    an_d = onehot ^ {NUM_DIGITS{POL}};
    seg_d = (visible ? glyph : SEG_BLANK) ^ {7{POL}};
    dp_d  = (visible && scan_if.dp_mask[idx_q]) ^ POL;
  end

  assign scan_if.an        = an_q;
  assign scan_if.seg       = seg_q;
  assign scan_if.dp        = dp_q;
  assign scan_if.digit_idx = idx_q;
  assign scan_if.blink_on  = (blink_q == VISIBLE);

endmodule

// File: tb/tb_seg_scan_controller.sv
// Self-checking bench for seg_scan_controller: a cycle model pushes expected pin
// states on each clock edge and the scenario tasks pop and compare them.
module tb_seg_scan_controller;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BD = 10;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] idx;
    logic       on;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg_scan_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_controller #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD),
    .BLINK_DIV  (BD),
    .ACTIVE_LOW (1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .scan_if(bus)
  );

  always #5 clk = ~clk;

  int   nChecks = 0;
  int   nFail   = 0;
  exp_t sb[$];

  int         mRcnt = 0;
  int         mBcnt = 0;
  logic [1:0] mIdx  = 2'd0;
  logic       mOn   = 1'b1;

  function automatic logic [6:0] hexSeg(input logic [3:0] v);
    logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[v];
  endfunction

  function automatic exp_t actual();
    return {bus.an, bus.seg, bus.dp, bus.digit_idx, bus.blink_on};
  endfunction

  // Reference model: outputs register from the pre-edge position, then the counters step.
  always @(posedge clk or posedge rst) begin
    exp_t e;
    logic vis;
    if (rst) begin
      mRcnt = 0;
      mBcnt = 0;
      mIdx  = 2'd0;
      mOn   = 1'b1;
      sb.delete();
    end else begin
      vis   = bus.enable && !(bus.blink_mask[mIdx] && !mOn);
      e.an  = vis ? ~(4'b0001 << mIdx) : 4'hF;
      e.seg = vis ? ~hexSeg(bus.digits[4*mIdx +: 4]) : 7'h7F;
      e.dp  = vis ? ~bus.dp_mask[mIdx] : 1'b1;
      if (mRcnt == RD - 1) begin
        mRcnt = 0;
        mIdx  = mIdx + 2'd1;
      end else begin
        mRcnt = mRcnt + 1;
      end
      if (bus.blink_restart) begin
        mBcnt = 0;
        mOn   = 1'b1;
      end else if (mBcnt == BD - 1) begin
        mBcnt = 0;
        mOn   = ~mOn;
      end else begin
        mBcnt = mBcnt + 1;
      end
      e.idx = mIdx;
      e.on  = mOn;
      sb.push_back(e);
    end
  end

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] bm,
                               input logic [3:0] dm, input logic en);
    bus.digits     = d;
    bus.blink_mask = bm;
    bus.dp_mask    = dm;
    bus.enable     = en;
  endtask

  task automatic test_reset();
    exp_t a;
    rst = 1'b1;
    bus.blink_restart = 1'b0;
    applyStimulus(16'h12AF, 4'b0000, 4'b0000, 1'b1);
    repeat (3) @(negedge clk);
    a = actual();
    nChecks++;
    if (a !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b1}) begin
      nFail++;
      $display("[TB] FAIL reset_state: got %h expected %h", a, {4'hF, 7'h7F, 1'b1, 2'd0, 1'b1});
    end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    exp_t e, a;
    logic [3:0] anTab [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    logic [6:0] sgTab [5] = '{~7'h71, ~7'h77, ~7'h5B, ~7'h06, ~7'h71};
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      a = actual();
      nChecks++;
      if (sb.size() == 0) begin
        nFail++;
        $display("[TB] FAIL scan_sb: no expected entry, got %h", a);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          nFail++;
          $display("[TB] FAIL scan_sb cycle %0d: got %h expected %h", c, a, e);
        end
      end
      if (c % 4 == 0) begin
        nChecks++;
        if (bus.an !== anTab[c/4] || bus.seg !== sgTab[c/4]) begin
          nFail++;
          $display("[TB] FAIL scan_slot %0d: an=%b seg=%h expected an=%b seg=%h",
                   c/4, bus.an, bus.seg, anTab[c/4], sgTab[c/4]);
        end
      end
    end
  endtask

  task automatic test_blink();
    exp_t e, a;
    logic prevOn;
    int   sinceToggle = 0;
    bit   seenToggle  = 0;
    bus.blink_mask = 4'b0100;
    prevOn = bus.blink_on;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      a = actual();
      nChecks++;
      if (sb.size() == 0) begin
        nFail++;
        $display("[TB] FAIL blink_sb: no expected entry, got %h", a);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          nFail++;
          $display("[TB] FAIL blink_sb cycle %0d: got %h expected %h", c, a, e);
        end
      end
      sinceToggle++;
      if (bus.blink_on !== prevOn) begin
        if (seenToggle) begin
          nChecks++;
          if (sinceToggle != BD) begin
            nFail++;
            $display("[TB] FAIL blink_period: got %0d cycles expected %0d", sinceToggle, BD);
          end
        end
        seenToggle  = 1;
        sinceToggle = 0;
        prevOn = bus.blink_on;
      end
      if (bus.an === 4'hF) begin
        nChecks++;
        if (bus.seg !== 7'h7F) begin
          nFail++;
          $display("[TB] FAIL blink_blank_seg: got %h expected 7f", bus.seg);
        end
      end
    end
  endtask

  task automatic test_blink_restart();
    exp_t e, a;
    bit   found = 0;
    int   waitCnt;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      a = actual();
      nChecks++;
      if (sb.size() == 0) begin
        nFail++;
        $display("[TB] FAIL restart_sb: no expected entry, got %h", a);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          nFail++;
          $display("[TB] FAIL restart_sb: got %h expected %h", a, e);
        end
      end
      if (mBcnt == BD - 1 && mOn == 1'b0) found = 1;
    end
    nChecks++;
    if (!found) begin
      nFail++;
      $display("[TB] FAIL restart_wait: got timeout required bcnt=9 with blink_on=0");
    end else begin
      bus.blink_restart = 1'b1;
      @(negedge clk);
      bus.blink_restart = 1'b0;
      a = actual();
      if (sb.size() != 0) e = sb.pop_front();
      nChecks++;
      if (a !== e || bus.blink_on !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL restart_edge: got %h expected %h", a, e);
      end
      waitCnt = 0;
      while (bus.blink_on === 1'b1 && waitCnt < 15) begin
        @(negedge clk);
        waitCnt++;
        a = actual();
        if (sb.size() != 0) begin
          e = sb.pop_front();
          nChecks++;
          if (a !== e) begin
            nFail++;
            $display("[TB] FAIL restart_sb_after: got %h expected %h", a, e);
          end
        end
      end
      nChecks++;
      if (waitCnt != BD) begin
        nFail++;
        $display("[TB] FAIL restart_toggle: got %0d cycles expected %0d", waitCnt, BD);
      end
    end
  endtask

  task automatic test_dp();
    exp_t e, a;
    bus.blink_mask = 4'b0000;
    bus.dp_mask    = 4'b0001;
    @(negedge clk);
    if (sb.size() != 0) void'(sb.pop_front());
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      a = actual();
      nChecks++;
      if (sb.size() == 0) begin
        nFail++;
        $display("[TB] FAIL dp_sb: no expected entry, got %h", a);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          nFail++;
          $display("[TB] FAIL dp_sb cycle %0d: got %h expected %h", c, a, e);
        end
      end
      nChecks++;
      if (bus.dp !== (bus.an === 4'b1110 ? 1'b0 : 1'b1)) begin
        nFail++;
        $display("[TB] FAIL dp_slot: an=%b dp=%b expected dp=%b", bus.an, bus.dp,
                 (bus.an === 4'b1110) ? 1'b0 : 1'b1);
      end
    end
  endtask

  task automatic test_enable();
    exp_t e, a;
    bus.enable = 1'b0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      a = actual();
      nChecks++;
      if (sb.size() == 0) begin
        nFail++;
        $display("[TB] FAIL enable_sb: no expected entry, got %h", a);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          nFail++;
          $display("[TB] FAIL enable_sb cycle %0d: got %h expected %h", c, a, e);
        end
      end
      if (c < 6) begin
        nChecks++;
        if (bus.an !== 4'hF) begin
          nFail++;
          $display("[TB] FAIL enable_blank cycle %0d: an=%b expected 1111", c, bus.an);
        end
      end
      if (c == 5) bus.enable = 1'b1;
    end
  endtask

  task automatic test_async_reset();
    exp_t e, a;
    int   guard = 0;
    while (!(mIdx == 2'd2 && mRcnt == 1) && guard < 40) begin
      @(negedge clk);
      guard++;
      if (sb.size() != 0) void'(sb.pop_front());
    end
    nChecks++;
    if (guard >= 40) begin
      nFail++;
      $display("[TB] FAIL areset_wait: got timeout required digit 2 mid-dwell");
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    a = actual();
    nChecks++;
    if (a !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b1}) begin
      nFail++;
      $display("[TB] FAIL areset_state: got %h expected %h", a, {4'hF, 7'h7F, 1'b1, 2'd0, 1'b1});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      a = actual();
      nChecks++;
      if (sb.size() == 0) begin
        nFail++;
        $display("[TB] FAIL areset_sb: no expected entry, got %h", a);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          nFail++;
          $display("[TB] FAIL areset_sb cycle %0d: got %h expected %h", c, a, e);
        end
      end
      if (c == 0) begin
        nChecks++;
        if (bus.an !== 4'b1110 || bus.digit_idx !== 2'd0) begin
          nFail++;
          $display("[TB] FAIL areset_restart: an=%b idx=%0d expected an=1110 idx=0",
                   bus.an, bus.digit_idx);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blink();
    test_blink_restart();
    test_dp();
    test_enable();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
